// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the single-cycle core.
//
// Owns the sequential fetch PC and issues in-order reads to instruction memory over a
// valid/ready handshake. Returned words are buffered, together with their PC, in a
// DEPTH-entry FIFO. A redirect from the core restarts fetch at a new address, flushes
// the FIFO and discards responses still in flight for the old stream.
//
// Parameters:
//   RESET_PC  fetch address after reset
//   DEPTH     FIFO entries and maximum outstanding requests (power of 2, >= 2)
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   redirect_valid, redirect_pc     fetch restart request from the core
//   imem_req_valid/ready/addr       read request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   in-order read response (always accepted)
//   fetch_fault                     misaligned redirect seen (IFU_MISALIGN_CHECK_EN only)
//   inst_valid, inst_ready          FIFO head handshake to the core
//   inst, inst_pc                   head instruction word and its PC
//
// Build option:
//   IFU_MISALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned address raises
//                          fetch_fault and stalls fetch until an aligned redirect. When
//                          undefined, the low two redirect address bits are ignored.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, rsp_pc_q;
  logic [CW-1:0] inflight_q, drop_cnt_q, count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          fault_q;
  logic [31:0]   redirect_tgt;
  logic [CW:0]   occupancy;
  logic          req_fire, push, pop;

`ifdef IFU_MISALIGN_CHECK_EN
  logic bad_align;
  assign redirect_tgt = redirect_pc;
  assign bad_align    = |redirect_pc[1:0];
  assign fetch_fault  = fault_q;
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign fault_q      = 1'b0;
`endif

  // A request is only issued if there will be a FIFO slot for its response, so
  // outstanding requests plus buffered words never exceed DEPTH.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !redirect_valid && !fault_q && (occupancy < CAP);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to a flushed stream are counted off by drop_cnt.
  assign push       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst       = data_q[rd_ptr_q];
  assign inst_pc    = pc_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= RESET_PC;
      end
    end else if (redirect_valid) begin
      // No request fires in a redirect cycle; a same-cycle response retires one
      // in-flight entry and is itself discarded.
      fetch_pc_q <= redirect_tgt;
      rsp_pc_q   <= redirect_tgt;
      inflight_q <= inflight_q - CW'(imem_rsp_valid);
      drop_cnt_q <= inflight_q - CW'(imem_rsp_valid);
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      fault_q    <= bad_align;
`endif
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
      inflight_q <= inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - 1'b1;
      if (push) begin
        data_q[wr_ptr_q] <= imem_rsp_data;
        pc_q[wr_ptr_q]   <= rsp_pc_q;
        rsp_pc_q         <= rsp_pc_q + 32'd4;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Credit accounting makes these impossible for a well-behaved memory.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(DEPTH))));
  a_rsp_has_req : assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (inflight_q == '0)));
  a_drop_le_inflight : assert property (@(posedge clk) disable iff (rst)
    (drop_cnt_q <= inflight_q) && (inflight_q <= CW'(DEPTH)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch. A memory model answers requests in order with a
// random latency; words for a flushed stream come back as 0xDEADBEEF. A model process
// tracks the expected fetch address, outstanding reads and the expected instruction
// stream (a queue of {pc, word}); a monitor compares DUT outputs against it.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  ifu_fetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
`ifdef IFU_MISALIGN_CHECK_EN
    .fetch_fault   (fetch_fault),
`endif
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;

  req_t        mem_q[$];  // reads accepted by memory, not yet answered
  ent_t        exp_q[$];  // instructions the core should see next, in order
  logic [31:0] fpc;       // expected next fetch address
  bit          fault;
  int          n_vec, n_err, n_pop;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, inputs driven just after the rising edge.
  task automatic step(input int prr, input int prsp, input int pir, input int prd);
    logic [1:0] lo;
    @(posedge clk);
    #1;
    imem_req_ready = ($urandom_range(0, 99) < prr);
    inst_ready     = ($urandom_range(0, 99) < pir);
    redirect_valid = ($urandom_range(0, 99) < prd);
    lo             = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    redirect_pc    = RESET_PC + ($urandom_range(0, 1023) << 2) + {30'b0, lo};
    if (mem_q.size() != 0 && $urandom_range(0, 99) < prsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].stale ? 32'hDEAD_BEEF : memword(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Reference model: applies what happened at the coming rising edge.
  initial begin : model
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mem_q.delete();
        exp_q.delete();
        fpc   = RESET_PC;
        fault = 1'b0;
        continue;
      end
      if (imem_rsp_valid && mem_q.size() != 0) begin
        req_t r;
        r = mem_q.pop_front();
        if (!r.stale && !redirect_valid) exp_q.push_back('{r.addr, memword(r.addr)});
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{fpc, 1'b0});
        fpc += 32'd4;
      end
      if (redirect_valid) begin
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
        fault = (redirect_pc[1:0] != 2'b00);
        fpc   = redirect_pc;
`else
        fpc   = {redirect_pc[31:2], 2'b00};
`endif
      end
    end
  end

  // Monitor: checks outputs mid-cycle and pops the scoreboard on each consume.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        continue;
      end
      chk("req_valid", {31'b0, imem_req_valid},
          {31'b0, !redirect_valid && !fault && (mem_q.size() + exp_q.size() < DEPTH)});
      if (imem_req_valid) chk("req_addr", imem_req_addr, fpc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
`ifdef IFU_MISALIGN_CHECK_EN
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, fault});
`endif
      if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.data);
        n_pop++;
      end
    end
  end

  initial begin : driver
    n_vec = 0; n_err = 0; n_pop = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) step(100, 100, 100, 0);   // streaming from RESET_PC
    repeat (12) step(100, 100, 0, 0);     // core stalled: FIFO fills, requests stop
    repeat (8)  step(100, 100, 100, 0);
    repeat (5)  step(0, 100, 100, 0);     // memory stalled: address held
    repeat (10) step(100, 30, 100, 0);
    step(100, 0, 100, 100);               // redirect with reads in flight
    repeat (20) step(100, 100, 100, 0);
    for (int b = 0; b < 15; b++) begin
      int prr, prsp, pir, prd;
      prr  = $urandom_range(30, 100);
      prsp = $urandom_range(30, 100);
      pir  = $urandom_range(30, 100);
      prd  = $urandom_range(0, 10);
      repeat (200) step(prr, prsp, pir, prd);
    end
    // Asynchronous reset in the middle of traffic.
    repeat (10) step(100, 100, 100, 0);
    @(posedge clk);
    #3;
    rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("async_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) step(80, 70, 80, 5);
    repeat (10) step(100, 100, 100, 0);
    @(negedge clk);
    chk("progress", {31'b0, n_pop > 300}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
